hex_block_tx_seq: RTL and testbench
===================================

Name: hex_block_tx_seq

Overview:
- Sequences one 128-bit block (AES ciphertext, plaintext or key) into 32 uppercase ASCII hex characters, most-significant nibble first.
- Characters are delivered one per valid/ready handshake to a byte-wide consumer, typically the UART transmit path.
- Sits between the AES core output register and the serial TX stage.
- Owns the nibble counter, the shift register and the character handshake.

Parameters:
- DATA_W, 128, block width in bits; must be a multiple of 4.
- NIB_W, 4, nibble width; fixed, not intended for override.
- CNT_W, 5, nibble counter width; must satisfy 2^CNT_W >= DATA_W/4.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- blk_valid  input  1  producer presents a block.
- blk_data  input  DATA_W  block to print; sampled only on accept.
- blk_ready  output  1  sequencer can accept a block.
- char_valid  output  1  char_data holds a valid ASCII byte.
- char_data  output  8  ASCII character.
- char_ready  input  1  consumer accepts char_data this cycle.
- busy  output  1  a block is being emitted.
- done  output  1  one-cycle pulse after the final character is accepted.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: blk_ready=0 during the rst cycle and 1 from the first cycle after; char_valid=0, char_data=0x00, busy=0, done=0, counter=0, shift register=0, state=IDLE.
- States: IDLE, SEND, plus CR and LF when the optional feature is enabled.
- IDLE:
  - blk_ready=1.
  - On blk_valid&blk_ready: load blk_data into the shift register, counter=DATA_W/4-1, go to SEND.
  - char_valid rises on the next cycle; accept-to-first-char latency is 1 cycle.
- SEND:
  - char_valid=1, char_data=ASCII(shift_reg[DATA_W-1 -: 4]), busy=1, blk_ready=0.
  - ASCII mapping: 0x0-0x9 -> 0x30-0x39; 0xA-0xF -> 0x41-0x46 (uppercase only).
  - On char_valid&char_ready: shift left by 4 and decrement the counter.
  - When the counter is 0 at accept, go to IDLE (or CR when the feature is enabled).
- Back-pressure:
  - While char_valid=1 and char_ready=0, char_data and all state hold.
  - char_valid never drops before acceptance.
- Throughput: one character per cycle when char_ready is held high, so 32 cycles per block.
- done:
  - Asserts for exactly 1 cycle, in the cycle after the final character handshake, coincident with the return to IDLE (blk_ready=1).
  - A new block may be accepted in that same cycle.
- blk_valid while busy: ignored, no accept, blk_data not sampled.
- char_ready while char_valid=0: ignored.
- Reset mid-block: the block is abandoned, no done pulse, and all outputs return to reset values on the next edge.
- Counter never wraps: the SEND exit is decided at counter==0, so no underflow is possible.

Optional Feature:
- Macro: HEX_SEQ_CRLF_EN.
- Defined:
  - After the last hex character is accepted, the FSM passes through CR (char_data=0x0D) then LF (char_data=0x0A), each under the same valid/ready rules, for 34 characters per block.
  - done pulses after LF is accepted.
- Undefined:
  - CR/LF states and logic are absent; 32 characters per block; done follows the last hex character.

Decomposition:
- Shared package (hex_seq_pkg): state encoding constants (ST_IDLE, ST_SEND, ST_CR, ST_LF), ASCII_CR=8'h0D, ASCII_LF=8'h0A, default DATA_W.
- Sub-module: hex_ascii, the combinational 4-bit-to-ASCII converter, instantiated once on the top nibble of the shift register.
- Everything else stays in the top module.

Test Plan:
- Basic block: blk_data=128'h00112233445566778899AABBCCDDEEFF with char_ready=1.
  - Expect 32 bytes "00112233445566778899AABBCCDDEEFF", i.e. 0x30,0x30,0x31,...,0x46,0x46.
  - First char_valid 1 cycle after accept; done 1 cycle after the last accept.
- Back-pressure: char_ready toggled 1,0,0,1 pattern on 128'h0123456789ABCDEFFEDCBA9876543210.
  - char_data held stable during every stall.
  - Exact sequence "0123456789ABCDEFFEDCBA9876543210", no drops or duplicates.
- Back-to-back: blk_valid held high with two blocks, 128'hFFFF...FF then 128'h0.
  - Second block accepted in the done cycle.
  - Output is 32x 0x46 followed by 32x 0x30.
- Busy rejection: pulse blk_valid with 128'h1234... during SEND.
  - blk_ready=0 and the in-flight character stream is unchanged.
- Reset mid-block: assert rst after 10 characters.
  - Next cycle char_valid=0, busy=0, char_data=0x00, no done pulse.
  - blk_ready=1 the following cycle.
- HEX_SEQ_CRLF_EN defined: block 128'hA5...A5.
  - Output "A5" x16, then 0x0D, 0x0A; done only after LF is accepted.

Source files
------------

// File: rtl/hex_seq_pkg.sv
// Shared definitions for the hex block sequencer: state encoding, control
// characters and the default block width.
package hex_seq_pkg;

    localparam int unsigned DEF_DATA_W = 128;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_t;

endpackage

// File: rtl/hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex_ascii (
    input  logic [3:0] nib,
    input  logic       unused_tie,
    output logic [7:0] ascii
);

    logic unused;

    always_comb begin
        unused = unused_tie;
        ascii  = '0;
        if (nib < 4'hA) begin
            ascii = {4'h3, nib};
        end else begin
            ascii = 8'h37 + {4'h0, nib};
        end
    end

endmodule

// File: rtl/hex_block_tx_seq.sv
// Prints one DATA_W-bit block as uppercase ASCII hex, MS nibble first, over a
// valid/ready byte interface. Define HEX_SEQ_CRLF_EN to append CR LF per block.
module hex_block_tx_seq
    import hex_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NIB_W  = 4,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    input  logic [DATA_W-1:0] blk_data,
    output logic              blk_ready,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              busy,
    output logic              done
);

    state_t             state;
    logic [DATA_W-1:0]  shift;
    logic [DATA_W-1:0]  shift_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         nib_ascii;
    logic               char_acc;

    // The converter looks at the value the shift register is about to take,
    // so char_data can be registered in the same edge as the load/shift.
    always_comb begin
        shift_nxt = {shift[DATA_W-NIB_W-1:0], {NIB_W{1'b0}}};
        if (state == ST_IDLE) begin
            shift_nxt = blk_data;
        end
    end

    assign char_acc = char_valid && char_ready;

    hex_ascii u_ascii (
        .nib        (shift_nxt[DATA_W-1 -: NIB_W]),
        .unused_tie (1'b0),
        .ascii      (nib_ascii)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            cnt        <= '0;
            blk_ready  <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    blk_ready <= 1'b1;
                    if (blk_valid && blk_ready) begin
                        shift      <= shift_nxt;
                        cnt        <= CNT_W'(DATA_W / NIB_W - 1);
                        char_data  <= nib_ascii;
                        char_valid <= 1'b1;
                        busy       <= 1'b1;
                        blk_ready  <= 1'b0;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (char_acc) begin
                        shift <= shift_nxt;
                        if (cnt == '0) begin
`ifdef HEX_SEQ_CRLF_EN
                            char_data <= ASCII_CR;
                            state     <= ST_CR;
`else
                            char_valid <= 1'b0;
                            char_data  <= '0;
                            busy       <= 1'b0;
                            blk_ready  <= 1'b1;
                            done       <= 1'b1;
                            state      <= ST_IDLE;
`endif
                        end else begin
                            cnt       <= cnt - CNT_W'(1);
                            char_data <= nib_ascii;
                        end
                    end
                end
`ifdef HEX_SEQ_CRLF_EN
                ST_CR: begin
                    if (char_acc) begin
                        char_data <= ASCII_LF;
                        state     <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (char_acc) begin
                        char_valid <= 1'b0;
                        char_data  <= '0;
                        busy       <= 1'b0;
                        blk_ready  <= 1'b1;
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_block_tx_seq.sv
// Directed self-checking bench for hex_block_tx_seq; honours HEX_SEQ_CRLF_EN.
module tb_hex_block_tx_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         char_valid;
    logic [7:0]   char_data;
    logic         char_ready;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

`ifdef HEX_SEQ_CRLF_EN
    localparam int NCH = 34;
`else
    localparam int NCH = 32;
`endif

    always #5 clk = ~clk;

    hex_block_tx_seq #(.DATA_W(128), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Characters 32 and 33 exist only with CR/LF enabled.
    function automatic logic [7:0] exp_char(input string s, input int i);
        if (i < 32) return s[i];
        else if (i == 32) return 8'h0D;
        else return 8'h0A;
    endfunction

    task automatic test_reset();
        rst = 1'b1; blk_valid = 1'b0; blk_data = '0; char_ready = 1'b0;
        tick(); tick();
        total++;
        if (blk_ready !== 1'b0 || char_valid !== 1'b0 || char_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals got rdy=%b v=%b d=%h busy=%b done=%b expected 0 0 00 0 0", blk_ready, char_valid, char_data, busy, done);
        end
        rst = 1'b0;
        tick();
        total++;
        if (blk_ready !== 1'b1 || char_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b v=%b expected rdy=1 v=0", blk_ready, char_valid);
        end
    endtask

    task automatic test_basic();
        string s = "00112233445566778899AABBCCDDEEFF";
        blk_data = 128'h00112233445566778899AABBCCDDEEFF;
        blk_valid = 1'b1; char_ready = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            total++;
            if (char_valid !== 1'b1 || char_data !== exp_char(s, i)) begin
                bad++;
                $display("FAIL basic_char[%0d] got v=%b d=%h expected v=1 d=%h", i, char_valid, char_data, exp_char(s, i));
            end
            total++;
            if (done !== 1'b0 || busy !== 1'b1 || blk_ready !== 1'b0) begin
                bad++;
                $display("FAIL basic_ctrl[%0d] got done=%b busy=%b rdy=%b expected 0 1 0", i, done, busy, blk_ready);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || blk_ready !== 1'b1 || char_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got done=%b rdy=%b v=%b busy=%b expected 1 1 0 0", done, blk_ready, char_valid, busy);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_width got done=%b expected 0", done);
        end
    endtask

    task automatic test_backpressure();
        string       s = "0123456789ABCDEFFEDCBA9876543210";
        logic [3:0]  pat = 4'b1001;
        logic [7:0]  held = '0;
        logic        prev_stall = 1'b0;
        int          n = 0;
        int          k = 0;
        blk_data = 128'h0123456789ABCDEFFEDCBA9876543210;
        blk_valid = 1'b1; char_ready = 1'b0;
        tick();
        blk_valid = 1'b0;
        while (n < NCH && k < 400) begin
            if (prev_stall) begin
                total++;
                if (char_valid !== 1'b1 || char_data !== held) begin
                    bad++;
                    $display("FAIL bp_hold[%0d] got v=%b d=%h expected v=1 d=%h", k, char_valid, char_data, held);
                end
            end
            char_ready = pat[k % 4];
            if (char_ready) begin
                total++;
                if (char_valid !== 1'b1 || char_data !== exp_char(s, n) || done !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_char[%0d] got v=%b d=%h done=%b expected v=1 d=%h done=0", n, char_valid, char_data, done, exp_char(s, n));
                end
                n++;
            end
            prev_stall = !char_ready;
            held = char_data;
            k++;
            tick();
        end
        total++;
        if (n < NCH) begin
            bad++;
            $display("FAIL bp_timeout got chars=%0d expected %0d", n, NCH);
        end
        char_ready = 1'b0;
        total++;
        if (done !== 1'b1 || blk_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_done got done=%b rdy=%b expected 1 1", done, blk_ready);
        end
        tick();
    endtask

    task automatic test_busy_reject();
        string s = "00112233445566778899AABBCCDDEEFF";
        blk_data = 128'h00112233445566778899AABBCCDDEEFF;
        blk_valid = 1'b1; char_ready = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (i == 5) begin
                blk_valid = 1'b1;
                blk_data  = 128'h123456789ABCDEF0123456789ABCDEF0;
                total++;
                if (blk_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_ready got rdy=%b expected 0", blk_ready);
                end
            end else begin
                blk_valid = 1'b0;
            end
            total++;
            if (char_valid !== 1'b1 || char_data !== exp_char(s, i)) begin
                bad++;
                $display("FAIL busy_char[%0d] got v=%b d=%h expected v=1 d=%h", i, char_valid, char_data, exp_char(s, i));
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL busy_done got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        string f = "FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF";
        string z = "00000000000000000000000000000000";
        blk_data = '1;
        blk_valid = 1'b1; char_ready = 1'b1;
        tick();
        blk_data = '0;
        for (int i = 0; i < NCH; i++) begin
            total++;
            if (char_valid !== 1'b1 || char_data !== exp_char(f, i)) begin
                bad++;
                $display("FAIL b2b_first[%0d] got v=%b d=%h expected v=1 d=%h", i, char_valid, char_data, exp_char(f, i));
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || blk_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done1 got done=%b rdy=%b expected 1 1", done, blk_ready);
        end
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            total++;
            if (char_valid !== 1'b1 || char_data !== exp_char(z, i) || done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_second[%0d] got v=%b d=%h done=%b expected v=1 d=%h done=0", i, char_valid, char_data, done, exp_char(z, i));
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done2 got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        blk_data = 128'h0123456789ABCDEFFEDCBA9876543210;
        blk_valid = 1'b1; char_ready = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (char_valid !== 1'b0 || busy !== 1'b0 || char_data !== 8'h00 || done !== 1'b0 || blk_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_vals got v=%b busy=%b d=%h done=%b rdy=%b expected 0 0 00 0 0", char_valid, busy, char_data, done, blk_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (blk_ready !== 1'b1 || done !== 1'b0 || char_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_after[%0d] got rdy=%b done=%b v=%b expected 1 0 0", i, blk_ready, done, char_valid);
            end
        end
    endtask

`ifdef HEX_SEQ_CRLF_EN
    task automatic test_crlf();
        string s = "A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5";
        blk_data = {16{8'hA5}};
        blk_valid = 1'b1; char_ready = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 34; i++) begin
            total++;
            if (char_valid !== 1'b1 || char_data !== exp_char(s, i) || done !== 1'b0) begin
                bad++;
                $display("FAIL crlf_char[%0d] got v=%b d=%h done=%b expected v=1 d=%h done=0", i, char_valid, char_data, done, exp_char(s, i));
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || blk_ready !== 1'b1) begin
            bad++;
            $display("FAIL crlf_done got done=%b rdy=%b expected 1 1", done, blk_ready);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
`ifdef HEX_SEQ_CRLF_EN
        test_crlf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
